xbusarb: RTL and testbench
==========================

Name: xbusarb

Overview:
- Two-master arbiter for the shared peripheral data bus (regf, prog, ps2, pushs, disp, gpo, oper).
- Master 0 is the controller data port. Master 1 is a DMA or auxiliary requester.
- Grants are registered. Arbitration is round-robin, with a burst limit and a per-master lock.
- The granted master's signals are forwarded to the address decoder side. Read data is returned to the granted master only.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
MAX_BURST, 8, consecutive owned cycles before forced hand-over when the other master waits (>=1)
CNT_W, 3, width of burst counter; must be >= clog2(MAX_BURST)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0_req  input  1  master 0 bus request
m0_lock  input  1  master 0 lock: no preemption while req and lock are held
m0_we  input  1  master 0 write enable
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_gnt  output  1  master 0 owns bus (registered)
m0_rdata  output  DATA_W  read data to master 0
m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata  same as m0_* for master 1
bus_sel  output  1  forwarded select to address decoder
bus_we  output  1  forwarded write enable
bus_addr  output  ADDR_W  forwarded address
bus_wdata  output  DATA_W  forwarded write data
bus_rdata  input  DATA_W  read data from decoder mux (same cycle)
owner  output  2  00 idle, 01 master 0, 10 master 1 (equals {m1_gnt,m0_gnt})

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values, applied at the first clk edge with rst=1:
  - state IDLE, m0_gnt=0, m1_gnt=0, burst_cnt=0, last=1 (master 0 wins the first tie).
  - Combinational outputs are then 0: bus_sel, bus_we, bus_addr, bus_wdata, m*_rdata.
- Reset mid-tenure: grant drops at that edge. bus_sel goes low in the same cycle the grant falls. No partial state is retained.
- States are IDLE, OWN0 and OWN1. Grants are a one-hot decode of the state.
- Transfer rule: a transfer occurs in any cycle where mX_gnt & mX_req.
  - bus_sel = mX_gnt & mX_req.
  - bus_we, bus_addr and bus_wdata are the owner's inputs, gated to 0 when there is no transfer.
  - Zero wait states: a read is completed by bus_rdata in the same cycle.
- mX_rdata = bus_rdata when mX_gnt, else 0.
- Latency: a request raised in IDLE is granted at the next edge. The first transfer occurs in the cycle after the request is first seen.
- IDLE transitions:
  - Only req0 -> OWN0. Only req1 -> OWN1.
  - Both -> the master with index != last.
  - Neither -> stay IDLE.
- OWNx transitions, with y = other master:
  - req_x=0: go to OWNy if req_y, else IDLE. Set last=x.
  - req_x=1 & lock_x=1: stay. Burst counting is frozen while lock is held.
  - req_x=1 & req_y=1 & burst_cnt==MAX_BURST-1: go to OWNy, set last=x.
  - Otherwise stay.
- Release cost: the cycle in which the owner drops req is a dead cycle with bus_sel=0.
- burst_cnt behaviour:
  - Cleared on every state change.
  - Increments each OWN cycle with no lock.
  - Saturates at MAX_BURST-1.
  - If saturated with no waiting master, the owner keeps the bus and switches on the first cycle req_y is seen.
- MAX_BURST=1: ownership alternates every cycle under contention.
- Simultaneous req rise from both masters in IDLE: decided by last. There is never a double grant; the bench asserts m0_gnt & m1_gnt is never 1.
- Lock asserted by a master that does not own the bus has no effect.
- Lock release while the counter is frozen below the limit: counting resumes from the frozen value.
- Starvation bound: with lock never asserted, a waiting master is granted within MAX_BURST+1 cycles of raising req.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then m0_req=1 with addr 0x10, we=0.
  - Required: m0_gnt=1 one cycle later, bus_sel=1, bus_addr=0x10, m0_rdata tracks bus_rdata, m1_rdata=0.
- Tie from IDLE, with MAX_BURST=8:
  - m0_req and m1_req rise together after reset. m0 is granted first.
  - After 8 owned cycles, m1_gnt=1. After 8 more, back to m0.
  - owner sequence is 01×8, 10×8, 01.
- Voluntary release:
  - m1 owns the bus and drops req after 3 transfers while m0 waits.
  - Required: one dead cycle with bus_sel=0, then m0_gnt=1. owner returns to 00 when neither requests.
- Lock:
  - m0 owns with m0_lock=1 for 20 cycles while m1_req=1. m1_gnt stays 0 throughout.
  - Lock drops at cycle 20. m1 must be granted within MAX_BURST cycles.
- Reset mid-operation:
  - rst=1 during an m1 write burst with bus_wdata=0xDEADBEEF.
  - At that edge m1_gnt=0, bus_sel=0, bus_wdata=0.
  - After rst release with both requesting, m0 is granted first.
- Random contention:
  - 10k cycles of random req and lock.
  - Check the one-hot grant, gated-to-zero bus outputs when idle, and the starvation bound with lock=0.

Source files
------------

// File: rtl/xbusarb.sv
//------------------------------------------------------------------------------
// Module      : xbusarb
// Description : Two-master round-robin arbiter for the shared peripheral data
//               bus, with a burst limit and per-master lock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module xbusarb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_sel,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(MAX_BURST - 1);

    logic [1:0]       r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_run;
    logic             w_xfer0;
    logic             w_xfer1;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_run   = 1'b0;
        case (r_state)
            c_IDLE: begin
                // On a tie, the master that did not own last wins.
                if (m0_req && m1_req) begin
                    w_state_nxt = r_last ? c_OWN0 : c_OWN1;
                end else if (m0_req) begin
                    w_state_nxt = c_OWN0;
                end else if (m1_req) begin
                    w_state_nxt = c_OWN1;
                end
            end
            c_OWN0: begin
                if (!m0_req) begin
                    w_state_nxt = m1_req ? c_OWN1 : c_IDLE;
                    w_last_nxt  = 1'b0;
                end else if (!m0_lock) begin
                    w_cnt_run = 1'b1;
                    if (m1_req && (r_cnt == c_CNT_MAX)) begin
                        w_state_nxt = c_OWN1;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            c_OWN1: begin
                if (!m1_req) begin
                    w_state_nxt = m0_req ? c_OWN0 : c_IDLE;
                    w_last_nxt  = 1'b1;
                end else if (!m1_lock) begin
                    w_cnt_run = 1'b1;
                    if (m0_req && (r_cnt == c_CNT_MAX)) begin
                        w_state_nxt = c_OWN0;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Counter restarts on every ownership change and saturates at the limit.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (w_cnt_run && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign m0_gnt  = (r_state == c_OWN0);
    assign m1_gnt  = (r_state == c_OWN1);
    assign owner   = {m1_gnt, m0_gnt};
    assign w_xfer0 = m0_gnt & m0_req;
    assign w_xfer1 = m1_gnt & m1_req;

    assign bus_sel   = w_xfer0 | w_xfer1;
    assign bus_we    = w_xfer0 ? m0_we    : (w_xfer1 ? m1_we    : 1'b0);
    assign bus_addr  = w_xfer0 ? m0_addr  : (w_xfer1 ? m1_addr  : '0);
    assign bus_wdata = w_xfer0 ? m0_wdata : (w_xfer1 ? m1_wdata : '0);

    assign m0_rdata = m0_gnt ? bus_rdata : '0;
    assign m1_rdata = m1_gnt ? bus_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_xbusarb.sv
//------------------------------------------------------------------------------
// Module      : tb_xbusarb
// Description : Self-checking bench for xbusarb (MAX_BURST=8 and MAX_BURST=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_xbusarb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_lock = 0, m0_we = 0;
    logic        m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [31:0] bus_rdata = 0;

    logic        a_m0_gnt, a_m1_gnt, a_bus_sel, a_bus_we;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata;
    logic [1:0]  a_owner;
    logic        b_m0_gnt, b_m1_gnt, b_bus_sel, b_bus_we;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata;
    logic [1:0]  b_owner;

    always #5 clk = ~clk;

    xbusarb #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .CNT_W(3)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(a_m0_gnt), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(a_m1_gnt), .m1_rdata(a_m1_rdata),
        .bus_sel(a_bus_sel), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
        .bus_wdata(a_bus_wdata), .bus_rdata(bus_rdata), .owner(a_owner)
    );

    xbusarb #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1), .CNT_W(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata),
        .bus_sel(b_bus_sel), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
        .bus_wdata(b_bus_wdata), .bus_rdata(bus_rdata), .owner(b_owner)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (0 none, 1 = m0, 2 = m1), last owner, burst count.
    int c_max [2] = '{8, 1};
    int mo_own [2];
    int mo_last [2];
    int mo_cnt [2];
    bit model_ok = 0;
    bit starve_on = 0;
    int wt [2][2];

    task automatic mstep(input int k);
        bit rq [2];
        bit lk [2];
        int x, y;
        rq[0] = m0_req; rq[1] = m1_req;
        lk[0] = m0_lock; lk[1] = m1_lock;
        if (rst) begin
            mo_own[k] = 0; mo_last[k] = 1; mo_cnt[k] = 0;
        end else if (mo_own[k] == 0) begin
            mo_cnt[k] = 0;
            if (rq[0] && rq[1]) mo_own[k] = (mo_last[k] == 0) ? 2 : 1;
            else if (rq[0])     mo_own[k] = 1;
            else if (rq[1])     mo_own[k] = 2;
        end else begin
            x = mo_own[k] - 1;
            y = 1 - x;
            if (!rq[x]) begin
                mo_own[k] = rq[y] ? y + 1 : 0;
                mo_last[k] = x; mo_cnt[k] = 0;
            end else if (lk[x]) begin
                mo_cnt[k] = mo_cnt[k];
            end else if (rq[y] && mo_cnt[k] == c_max[k] - 1) begin
                mo_own[k] = y + 1;
                mo_last[k] = x; mo_cnt[k] = 0;
            end else if (mo_cnt[k] < c_max[k] - 1) begin
                mo_cnt[k]++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            mstep(0);
            mstep(1);
            if (rst) model_ok = 1;
        end
    end

    task automatic cmp(input int k, input logic g0, input logic g1, input logic sel,
                       input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd0, input logic [31:0] rd1, input logic [1:0] own);
        bit        xfer;
        logic      e_we;
        logic [31:0] e_addr, e_wdata;
        bit        rq [2];
        bit        gg [2];
        rq[0] = m0_req; rq[1] = m1_req;
        gg[0] = g0; gg[1] = g1;
        xfer = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        if (mo_own[k] == 1 && m0_req) begin
            xfer = 1; e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata;
        end else if (mo_own[k] == 2 && m1_req) begin
            xfer = 1; e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata;
        end
        chk($sformatf("owner%0d", k), own, mo_own[k]);
        chk($sformatf("m0_gnt%0d", k), g0, mo_own[k] == 1);
        chk($sformatf("m1_gnt%0d", k), g1, mo_own[k] == 2);
        chk($sformatf("one_hot%0d", k), g0 & g1, 0);
        chk($sformatf("bus_sel%0d", k), sel, xfer);
        chk($sformatf("bus_we%0d", k), we, e_we);
        chk($sformatf("bus_addr%0d", k), addr, e_addr);
        chk($sformatf("bus_wdata%0d", k), wdata, e_wdata);
        chk($sformatf("m0_rdata%0d", k), rd0, (mo_own[k] == 1) ? bus_rdata : 32'h0);
        chk($sformatf("m1_rdata%0d", k), rd1, (mo_own[k] == 2) ? bus_rdata : 32'h0);
        for (int m = 0; m < 2; m++) begin
            if (starve_on && rq[m] && !gg[m]) begin
                wt[k][m]++;
                chk($sformatf("starve%0d_m%0d", k, m), (wt[k][m] <= c_max[k] + 1), 1);
            end else begin
                wt[k][m] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                cmp(0, a_m0_gnt, a_m1_gnt, a_bus_sel, a_bus_we, a_bus_addr, a_bus_wdata,
                    a_m0_rdata, a_m1_rdata, a_owner);
                cmp(1, b_m0_gnt, b_m1_gnt, b_bus_sel, b_bus_we, b_bus_addr, b_bus_wdata,
                    b_m0_rdata, b_m1_rdata, b_owner);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus_rdata = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin : main
        bit found;
        int exp_a, exp_b;

        // Reset then a single read request from master 0
        tick();
        settle();
        chk("rst_m0_gnt", a_m0_gnt, 0);
        chk("rst_m1_gnt", a_m1_gnt, 0);
        chk("rst_bus_sel", a_bus_sel, 0);
        chk("rst_owner", a_owner, 2'b00);
        tick();
        rst = 0; m0_req = 1; m0_addr = 32'h10; m0_we = 0;
        settle();
        chk("req_seen_owner", a_owner, 2'b00);
        tick();
        settle();
        chk("first_m0_gnt", a_m0_gnt, 1);
        chk("first_bus_sel", a_bus_sel, 1);
        chk("first_bus_addr", a_bus_addr, 32'h10);
        chk("first_m0_rdata", a_m0_rdata, bus_rdata);
        chk("first_m1_rdata", a_m1_rdata, 0);

        // Tie from IDLE after reset
        tick();
        m0_req = 0; rst = 1;
        tick();
        rst = 0; m0_req = 1; m1_req = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            settle();
            exp_a = (i < 8) ? 1 : ((i < 16) ? 2 : 1);
            exp_b = (i % 2 == 0) ? 1 : 2;
            chk("tie_owner_mb8", a_owner, exp_a);
            chk("tie_owner_mb1", b_owner, exp_b);
        end

        // Voluntary release by master 1 with master 0 waiting
        tick();
        rst = 1; m0_req = 0; m1_req = 0;
        tick();
        rst = 0; m1_req = 1;
        tick();
        settle();
        chk("rel_m1_gnt", a_m1_gnt, 1);
        chk("rel_xfer1", a_bus_sel, 1);
        tick();
        m0_req = 1;
        settle();
        chk("rel_xfer2", a_m1_gnt & a_bus_sel, 1);
        tick();
        settle();
        chk("rel_xfer3", a_m1_gnt & a_bus_sel, 1);
        tick();
        m1_req = 0;
        settle();
        chk("rel_dead_sel", a_bus_sel, 0);
        chk("rel_dead_gnt", a_m1_gnt, 1);
        tick();
        settle();
        chk("rel_m0_gnt", a_m0_gnt, 1);
        chk("rel_m0_sel", a_bus_sel, 1);
        tick();
        m0_req = 0;
        settle();
        chk("rel_m0_dead", a_bus_sel, 0);
        tick();
        settle();
        chk("rel_idle_owner", a_owner, 2'b00);

        // Lock held by master 0 for 20 cycles
        rst = 1;
        tick();
        rst = 0; m0_req = 1; m0_lock = 1; m1_req = 1;
        tick();
        for (int i = 0; i < 20; i++) begin
            settle();
            chk("lock_m1_gnt", a_m1_gnt, 0);
            tick();
        end
        m0_lock = 0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            settle();
            if (a_m1_gnt) found = 1;
        end
        chk("lock_release_grant", found, 1);

        // Reset during a master-1 write burst
        tick();
        rst = 1; m0_req = 0; m1_req = 0;
        tick();
        rst = 0; m1_req = 1; m1_we = 1; m1_wdata = 32'hDEADBEEF; m1_addr = 32'h20;
        tick();
        settle();
        chk("mid_wdata", a_bus_wdata, 32'hDEADBEEF);
        chk("mid_we", a_bus_we, 1);
        tick();
        rst = 1;
        tick();
        settle();
        chk("mid_rst_m1_gnt", a_m1_gnt, 0);
        chk("mid_rst_sel", a_bus_sel, 0);
        chk("mid_rst_wdata", a_bus_wdata, 0);
        tick();
        rst = 0; m0_req = 1;
        tick();
        settle();
        chk("mid_after_m0_gnt", a_m0_gnt, 1);
        chk("mid_after_m1_gnt", a_m1_gnt, 0);

        // Random contention: first with lock, then lock-free with starvation bound
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (i == 2000) starve_on = 1;
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m0_lock  = (i < 2000) ? ($urandom_range(0, 3) == 0) : 1'b0;
            m1_lock  = (i < 2000) ? ($urandom_range(0, 3) == 0) : 1'b0;
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
        end
        tick();
        starve_on = 0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
